// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit beside the execute-stage ALU.
// Handles MULT, MULTU, DIV, DIVU (33 cycles, one bit per cycle) and the
// single-cycle MTHI/MTLO moves into the architectural HI/LO registers.
//
// Handshake: start is sampled only on a rising edge where busy=0. An accepted
// multiply/divide raises busy for 33 cycles; done pulses for exactly one cycle
// once HI/LO hold the result. start while busy=1 is dropped. A divide by zero
// completes at the acceptance edge itself: done and div_by_zero pulse in the
// next cycle, busy never rises and HI/LO keep their values.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        operation request
//   op           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   data1        rs: multiplicand / dividend / MTHI-MTLO source
//   data2        rt: multiplier / divisor
//   busy         operation in flight
//   done         one-cycle completion pulse for MULT/DIV ops
//   div_by_zero  one-cycle pulse with done when a divide had divisor 0
//   hi, lo       architectural HI/LO registers
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;       // product high half / partial remainder
  logic [31:0] mq_q, mq_d;         // multiplier / quotient shift register
  logic [31:0] mcand_q, mcand_d;   // multiplicand / divisor magnitude
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d; // negate product or quotient in FIX
  logic        neg_rem_q, neg_rem_d; // negate remainder in FIX
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  // Operand magnitudes: signed ops take |x|, unsigned ops use raw values.
  logic        op_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed && data1[31];
  assign b_neg     = op_signed && data2[31];
  assign a_mag     = a_neg ? (32'd0 - data1) : data1;
  assign b_mag     = b_neg ? (32'd0 - data2) : data2;

  // Shift-add step: conditionally add multiplicand, then shift {acc, mq} right.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : 33'd0);

  // Restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The partial remainder stays below the
  // divisor, so the low 32 bits of the difference are exact.
  logic [32:0] div_shift;
  logic        div_ge;
  assign div_shift = {acc_q, mq_q[31]};
  assign div_ge    = div_shift >= {1'b0, mcand_q};

  logic [63:0] prod_fix;
  assign prod_fix = neg_res_q ? (64'd0 - {acc_q, mq_q}) : {acc_q, mq_q};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              mcand_d   = a_mag;
              mq_d      = b_mag;
              acc_d     = 32'd0;
              cnt_d     = 5'd0;
              is_div_d  = 1'b0;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              state_d   = S_CALC;
            end
            OP_DIV, OP_DIVU: begin
              if (data2 == 32'd0) begin
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                mq_d      = a_mag;
                mcand_d   = b_mag;
                acc_d     = 32'd0;
                cnt_d     = 5'd0;
                is_div_d  = 1'b1;
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                state_d   = S_CALC;
              end
            end
            OP_MTHI: hi_d = data1;
            OP_MTLO: lo_d = data1;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_d = div_ge ? (div_shift[31:0] - mcand_q) : div_shift[31:0];
          mq_d  = {mq_q[30:0], div_ge};
        end else begin
          acc_d = mul_sum[32:1];
          mq_d  = {mul_sum[0], mq_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_res_q ? (32'd0 - mq_q) : mq_q;
          hi_d = neg_rem_q ? (32'd0 - acc_q) : acc_q;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= 32'd0;
      mq_q      <= 32'd0;
      mcand_q   <= 32'd0;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus randomized ops. The driver
// pushes the reference result ({div_by_zero, hi, lo}) into exp_q when an op
// is issued; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .data1       (data1),
    .data2       (data2),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int          done_expected = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  logic [31:0] model_hi, model_lo;
  logic [31:0] prev_hi, prev_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic. Returns {dbz, hi, lo}.
  function automatic logic [64:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] cur_hi,
                                             input logic [31:0] cur_lo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (o)
      3'd0: begin p = sa * sb; return {1'b0, p}; end
      3'd1: begin p = ua * ub; return {1'b0, p}; end
      3'd2: begin
        if (b == 32'd0) return {1'b1, cur_hi, cur_lo};
        sq = sa / sb; sr = sa % sb;
        q = sq; r = sr;
        return {1'b0, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {1'b1, cur_hi, cur_lo};
        uq = ua / ub; ur = ua % ub;
        q = uq; r = ur;
        return {1'b0, r[31:0], q[31:0]};
      end
      3'd4: return {1'b0, a, cur_lo};
      3'd5: return {1'b0, cur_hi, a};
      default: return {1'b0, cur_hi, cur_lo};
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && div_by_zero && !done) begin
      checks++;
      errors++;
      $display("FAIL dbz_without_done actual=1 expected=0 at %0t", $time);
    end
    if (rst_n && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_dbz", {63'd0, div_by_zero}, {63'd0, mon_e[64]});
        check("done_hi", {32'd0, hi}, {32'd0, mon_e[63:32]});
        check("done_lo", {32'd0, lo}, {32'd0, mon_e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge following the acceptance edge,
  // with data/op scrambled to show operands were captured.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit track);
    logic [64:0] e;
    e = ref_result(o, a, b, model_hi, model_lo);
    prev_hi = model_hi;
    prev_lo = model_lo;
    start = 1'b1;
    op    = o;
    data1 = a;
    data2 = b;
    if (track) begin
      if (o <= 3'd3) begin
        exp_q.push_back(e);
        done_expected++;
      end
      model_hi = e[63:32];
      model_lo = e[31:0];
    end
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    data1 = $urandom;
    data2 = $urandom;
  endtask

  // Counts busy cycles (sampled at negedges) and checks HI/LO hold still.
  task automatic wait_idle(input int already, input int exp_busy);
    int n;
    n = already;
    while (busy && n < 200) begin
      check("hilo_stable", {hi, lo}, {prev_hi, prev_lo});
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'(exp_busy));
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit long_op;
    long_op = (o <= 3'd1) || ((o == 3'd2 || o == 3'd3) && b != 32'd0);
    start_op(o, a, b, 1'b1);
    wait_idle(0, long_op ? 33 : 0);
    check("hilo_after", {hi, lo}, {model_hi, model_lo});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    data1 = 32'd0;
    data2 = 32'd0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    prev_hi  = 32'd0;
    prev_lo  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {29'd0, busy, done, div_by_zero, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(3'd0, 32'hFFFFFFFD, 32'd7);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2);
    run_op(3'd3, 32'd100, 32'd7);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op(3'd4, 32'h11, 32'd0);
    run_op(3'd5, 32'h22, 32'd0);
    run_op(3'd3, 32'd5, 32'd0);
    check("dbz_hilo_kept", {hi, lo}, {32'h11, 32'h22});
    run_op(3'd6, 32'hDEAD, 32'hBEEF);

    // start while busy is ignored
    start_op(3'd0, 32'd3, 32'd4, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = 3'd2;
    data1 = 32'd9;
    data2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    data1 = $urandom;
    data2 = $urandom;
    wait_idle(10, 33);
    check("busy_ignore_result", {hi, lo}, {32'd0, 32'd12});

    // asynchronous reset mid-operation
    start_op(3'd1, 32'h0000FFFF, 32'h0000FFFF, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", {30'd0, busy, done, hi}, 64'd0);
    check("async_reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_hi = 32'd0;
    model_lo = 32'd0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {62'd0, busy, done}, 64'd0);
    run_op(3'd0, 32'd2, 32'd3);

    // Randomized ops, issued back-to-back
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: ra = 32'($urandom_range(0, 1000));
        1: ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 50));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_seen), 64'(done_expected));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
